// File: rtl/cram_save_arbiter_pkg.sv
// Shared encodings for the cart-RAM save arbiter: read-return tags and FSM states.
package cram_save_arbiter_pkg;

    localparam int ADDR_W_DEF = 17;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_CPU  = 2'd1,
        TAG_BK   = 2'd2
    } tag_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BK_WR = 2'd1,
        BK_RD = 2'd2
    } state_t;

endpackage

// File: rtl/cram_save_arbiter_rd_tag_pipe.sv
// RD_LAT-deep shift register of read tags; pop_tag lines up with mem_rdata of the tagged read.
module cram_save_arbiter_rd_tag_pipe
    import cram_save_arbiter_pkg::*;
#(
    parameter int RD_LAT = 2
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic [1:0] push_tag,
    output logic [1:0] pop_tag
);

    tag_t stage [RD_LAT];

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < RD_LAT; i++) stage[i] <= TAG_NONE;
        end else begin
            stage[0] <= tag_t'(push_tag);
            for (int i = 1; i < RD_LAT; i++) stage[i] <= stage[i-1];
        end
    end

    assign pop_tag = stage[RD_LAT-1];

endmodule

// File: rtl/cram_save_arbiter.sv
// Shares the cart-RAM port between the CPU path (absolute priority) and the save engine.
// The memory bus is registered; mem_rdata is expected RD_LAT cycles after a read appears on it.
module cram_save_arbiter
    import cram_save_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int RD_LAT = 2
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic [7:0]        cpu_rdata,
    input  logic              bk_req,
    input  logic              bk_we,
    input  logic [ADDR_W-1:0] bk_addr,
    input  logic [7:0]        bk_wdata,
    output logic [7:0]        bk_rdata,
    output logic              bk_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              busy
);

    state_t            state, state_nxt;
    tag_t              bus_tag, bus_tag_nxt, pop_tag;
    logic [1:0]        pop_raw;
    logic              cpu_sel, bk_issue, bk_local;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic              mem_we_nxt;
    logic [7:0]        mem_wdata_nxt;
    logic              bk_ack_nxt;
    logic [7:0]        bk_rdata_nxt, cpu_rdata_nxt;

    assign cpu_sel = cpu_rd | cpu_wr;
    // The ack cycle is excluded so a requester still holding bk_req is not re-served.
    assign bk_issue = !cpu_sel && (state == IDLE) && !bk_ack && bk_req && enable;
    assign bk_local = (state == IDLE) && !bk_ack && bk_req && !enable;
    assign busy     = (state != IDLE);

    // bus_tag travels with the registered bus, so it is the tag of the read now on mem_addr.
    cram_save_arbiter_rd_tag_pipe #(.RD_LAT(RD_LAT)) u_tag_pipe (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .push_tag (bus_tag),
        .pop_tag  (pop_raw)
    );
    assign pop_tag = tag_t'(pop_raw);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        state_nxt = state;
        unique case (state)
            IDLE:    if (bk_issue) state_nxt = bk_we ? BK_WR : BK_RD;
            BK_WR:   state_nxt = IDLE;
            BK_RD:   if (pop_tag == TAG_BK) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        mem_we_nxt    = 1'b0;
        bus_tag_nxt   = TAG_NONE;
        if (cpu_sel) begin
            mem_addr_nxt  = cpu_addr;
            mem_wdata_nxt = cpu_wdata;
            mem_we_nxt    = cpu_wr;
            bus_tag_nxt   = cpu_wr ? TAG_NONE : TAG_CPU;
        end else if (bk_issue) begin
            mem_addr_nxt  = bk_addr;
            mem_wdata_nxt = bk_wdata;
            mem_we_nxt    = bk_we;
            bus_tag_nxt   = bk_we ? TAG_NONE : TAG_BK;
        end

        bk_ack_nxt    = (state == BK_WR);
        bk_rdata_nxt  = bk_rdata;
        cpu_rdata_nxt = cpu_rdata;
        if (pop_tag == TAG_BK) begin
            bk_ack_nxt   = 1'b1;
            bk_rdata_nxt = mem_rdata;
        end
        if (pop_tag == TAG_CPU) cpu_rdata_nxt = mem_rdata;
        // Without cart RAM the save engine still completes, reading erased-flash 0xFF.
        if (bk_local) begin
            bk_ack_nxt   = 1'b1;
            bk_rdata_nxt = 8'hFF;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= 8'h00;
            bus_tag   <= TAG_NONE;
            bk_ack    <= 1'b0;
            bk_rdata  <= 8'h00;
            cpu_rdata <= 8'h00;
        end else begin
            mem_addr  <= mem_addr_nxt;
            mem_we    <= mem_we_nxt;
            mem_wdata <= mem_wdata_nxt;
            bus_tag   <= bus_tag_nxt;
            bk_ack    <= bk_ack_nxt;
            bk_rdata  <= bk_rdata_nxt;
            cpu_rdata <= cpu_rdata_nxt;
        end
    end

endmodule

// File: doc/cram_save_arbiter.md
Name: cram_save_arbiter

Overview:
Shares the single cartridge-RAM port (cram) between the mapper/CPU path and the battery-save backup engine, which streams cart RAM to and from the save file.
- The CPU path always has absolute priority, because the Game Boy bus cannot be stalled.
- Backup requests are slotted into idle cycles.
- The block sits between the active mapper's cram interface and the external SRAM wrapper.
- Read data returns after a fixed pipeline latency, and the block tags each read to route it back to the correct requester.

Parameters:
ADDR_W, 17, cart-RAM byte address width (128 KB max).
RD_LAT, 2, memory read latency in clk_sys cycles (1..4).

Ports:
clk_sys  in  1  system clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  cart has RAM; when low, backup requests are answered locally
cpu_rd  in  1  CPU cram read, level, held for the whole CPU access
cpu_wr  in  1  CPU cram write, level; cpu_wr has priority over cpu_rd if both are high
cpu_addr  in  ADDR_W  CPU address, already banked by the mapper
cpu_wdata  in  8  CPU write data
cpu_rdata  out  8  read data for the CPU
bk_req  in  1  backup request; held until bk_ack
bk_we  in  1  1 = write to RAM (restore), 0 = read (save)
bk_addr  in  ADDR_W  backup address
bk_wdata  in  8  backup write data
bk_rdata  out  8  backup read data, valid with bk_ack
bk_ack  out  1  one-cycle completion pulse
mem_addr  out  ADDR_W  memory address
mem_we  out  1  memory write strobe, one cycle
mem_wdata  out  8  memory write data
mem_rdata  in  8  memory read data, RD_LAT cycles after issue
busy  out  1  backup transaction in flight

Behaviour:
- Reset (async, reset_n low):
  - State IDLE.
  - bk_ack=0, bk_rdata=0, cpu_rdata=0, busy=0.
  - Tag pipe cleared.
  - mem_we=0, mem_addr=0, mem_wdata=0.
- Issue-slot select, combinational each cycle:
  - cpu_sel = cpu_rd | cpu_wr.
  - When cpu_sel, the memory bus carries cpu_addr and cpu_wdata, and mem_we = cpu_wr.
- Backup issue:
  - Allowed only in a cycle with cpu_sel=0, state IDLE, bk_req=1 and enable=1.
  - The memory bus then carries bk_addr and bk_wdata, with mem_we = bk_we.
- Otherwise the bus holds its last address and mem_we=0.
- States:
  - IDLE: a backup issue moves the block to BK_WR if bk_we=1, else to BK_RD.
  - BK_WR: pulse bk_ack next cycle, then return to IDLE.
  - BK_RD: wait for the tagged read data. On return, register mem_rdata into bk_rdata, pulse bk_ack in the same cycle, and return to IDLE.
- Read tagging:
  - RD_LAT-deep shift register of 2-bit tags: {none, cpu, bk}.
  - A tag is pushed at issue and popped RD_LAT cycles later.
  - Popping a cpu tag loads cpu_rdata.
  - Popping a bk tag loads bk_rdata and pulses bk_ack.
  - cpu_rdata holds its value between CPU reads.
- CPU activity during a backup read does not abort the in-flight read. Data returns per its tag; CPU reads issued behind it get their own tags.
- Only one backup transaction is in flight at a time. bk_req stays ignored until after the cycle in which bk_ack is asserted.
- busy = (state != IDLE).
- enable=0:
  - A pending bk_req is acked one cycle later without touching memory.
  - bk_rdata = 8'hFF; no write occurs.
  - CPU accesses still pass through.
- Reset mid-transaction: all in-flight tags are dropped and no ack is produced.
- Backup starvation is permitted under continuous CPU access. A CPU access never waits.

Decomposition:
- Shared package: tag encoding (TAG_NONE=0, TAG_CPU=1, TAG_BK=2), state encoding (IDLE, BK_WR, BK_RD), ADDR_W default.
- One sub-module, rd_tag_pipe: parameterised RD_LAT shift register with push tag in and pop tag out.

Test Plan:
1. Reset-value check: assert reset_n=0 mid-run, then compare every output against the reset values above.
2. CPU-only read: cpu_rd=1, addr=0x0123, memory model returns 0x5A. Required: cpu_rdata=0x5A at issue+RD_LAT; bk_ack never asserts.
3. Backup write into an idle bus: bk_req, bk_we=1, addr=0x1FFFF, data=0x3C. Required: mem_we pulses exactly once with addr 0x1FFFF; bk_ack one cycle later; memory holds 0x3C.
4. Backup read, then CPU read back-to-back:
   - Stimulus: bk read of 0x0010 (holding 0xA1) issued; CPU reads 0x0020 (holding 0xB2) the next cycle.
   - Required: bk_rdata=0xA1 with bk_ack, then cpu_rdata=0xB2 one cycle later; no cross-routing.
5. Collision: bk_req and cpu_wr asserted together. Required: the CPU write goes first; the backup issues in the first cycle with cpu idle; bk_ack is delayed, never lost.
6. enable=0 with bk_req, bk_we=0. Required: bk_ack after 1 cycle, bk_rdata=0xFF, no mem_we. Also: reset during BK_RD produces no bk_ack afterward.
